// File: rtl/bcd_scan_driver4_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_driver4_if
// Load/status bundle between a value producer and bcd_scan_driver4.
//   load  : producer -> driver, one-cycle strobe to capture value
//   value : producer -> driver, 14-bit unsigned binary value
//   busy  : driver -> producer, conversion in progress (load ignored)
//   done  : driver -> producer, one-cycle pulse as the digits update
//   ovf   : driver -> producer, last accepted value exceeded 9999
// -----------------------------------------------------------------------------
interface bcd_scan_driver4_if;
   logic        load;
   logic [13:0] value;
   logic        busy;
   logic        done;
   logic        ovf;

   modport master (output load, output value, input busy, input done, input ovf);
   modport slave  (input load, input value, output busy, output done, output ovf);
endinterface

// File: rtl/bcd_scan_driver4.sv
// -----------------------------------------------------------------------------
// bcd_scan_driver4
// Converts a 14-bit binary value to four BCD digits with a sequential
// shift-add-3 engine and time-multiplexes them onto one digit bus for a
// 4-digit common-anode display driven through a BCD-to-7-segment decoder.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous, active-high reset
//   bus    : bcd_scan_driver4_if.slave (load, value, busy, done, ovf)
//   digit  : BCD nibble of the selected digit, 4'hF = blank
//   an_n   : active-low digit enables, bit0 = least significant digit
//
// Parameters:
//   SCAN_DIV : clk cycles each digit stays selected (>= 1)
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN : blank zero digits above the most significant
//                           nonzero digit (d0 is never blanked)
// -----------------------------------------------------------------------------
module bcd_scan_driver4 #(
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   bcd_scan_driver4_if.slave bus,
   output logic [3:0]        digit,
   output logic [3:0]        an_n
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t          state_q, state_d;
   logic [13:0]     sh_q, sh_d;
   logic [15:0]     acc_q, acc_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ovf_pend_q, ovf_pend_d;
   logic            ovf_q, ovf_d;
   logic [3:0][3:0] d_q, d_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]      idx_q, idx_d;

   logic [15:0]     acc_adj;
   logic [3:0][3:0] dig_norm;
   logic            busy, done;

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      acc_adj = acc_q;
      for (int n = 0; n < 4; n++) begin
         if (acc_q[4*n +: 4] >= 4'd5)
            acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
   end

   // Digit values for a normal (<= 9999) result.
   always_comb begin
      dig_norm = acc_q;
`ifdef LEADING_ZERO_BLANK_EN
      if (acc_q[15:12] == 4'd0) begin
         dig_norm[3] = 4'hF;
         if (acc_q[11:8] == 4'd0) begin
            dig_norm[2] = 4'hF;
            if (acc_q[7:4] == 4'd0)
               dig_norm[1] = 4'hF;
         end
      end
`endif
   end

   // Conversion FSM: next state, datapath next values and status outputs.
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      d_d        = d_q;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               sh_d       = bus.value;
               acc_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (bus.value > 14'd9999);
               state_d    = CONV;
            end
         end
         CONV: begin
            busy  = 1'b1;
            // Shift {acc,sh} left by one using the corrected nibbles.
            acc_d = {acc_adj[14:0], sh_q[13]};
            sh_d  = {sh_q[12:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13)
               state_d = DONE;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
            // Digits change only here, so a partial result is never shown.
            if (ovf_pend_q) begin
               d_d   = {4{4'hF}};
               ovf_d = 1'b1;
            end else begin
               d_d   = dig_norm;
               ovf_d = 1'b0;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running scan divider, independent of the conversion FSM.
   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sh_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         // NOTE: the digit registers are reset because they are visible on
         // the display; the shift/accumulator datapath is reset only for
         // deterministic simulation, its contents are reloaded on every load.
         d_q        <= '0;
         div_q      <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
         d_q        <= d_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.ovf  = ovf_q;

   // Display outputs decode registers only; load/value cannot reach them.
   assign digit = d_q[idx_q];
   assign an_n  = ~(4'b0001 << idx_q);

endmodule

// File: tb/tb_bcd_scan_driver4.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_driver4
// Directed self-checking bench for bcd_scan_driver4 with SCAN_DIV = 4.
// Honours LEADING_ZERO_BLANK_EN for the expected digit values.
// -----------------------------------------------------------------------------
module tb_bcd_scan_driver4;

   logic       clk;
   logic       rst;
   logic [3:0] digit;
   logic [3:0] an_n;
   int         checks = 0;
   int         fails  = 0;

   bcd_scan_driver4_if bus ();

   bcd_scan_driver4 #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .digit (digit),
      .an_n  (an_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for digit position pos to be selected, then check it.
   task automatic read_digit(input string tag, input int pos, input logic [3:0] exp);
      logic [3:0] want_an;
      want_an = ~(4'b0001 << pos);
      for (int i = 0; i < 20 && an_n !== want_an; i++) tick();
      check({tag, "_an"}, an_n, want_an);
      check(tag, digit, exp);
   endtask

   task automatic check_digits(input string tag, input logic [3:0] e3, input logic [3:0] e2,
                               input logic [3:0] e1, input logic [3:0] e0);
      read_digit({tag, "_d0"}, 0, e0);
      read_digit({tag, "_d1"}, 1, e1);
      read_digit({tag, "_d2"}, 2, e2);
      read_digit({tag, "_d3"}, 3, e3);
   endtask

   // Pulse load, then follow busy; optionally drive a second load at busy
   // cycle xat (which must be ignored).
   task automatic convert(input string tag, input logic [13:0] v, input int xat,
                          input logic [13:0] xv);
      int n, dn, dl;
      bus.load  = 1'b1;
      bus.value = v;
      tick();
      bus.load = 1'b0;
      n = 0; dn = 0; dl = 0;
      while (bus.busy && n < 40) begin
         n++;
         if (bus.done) begin
            dn++;
            dl = n;
         end
         bus.load  = (n == xat);
         bus.value = (n == xat) ? xv : v;
         tick();
      end
      bus.load = 1'b0;
      check({tag, "_busy_cycles"}, n, 15);
      check({tag, "_done_count"}, dn, 1);
      check({tag, "_done_cycle"}, dl, 15);
      tick();
      check({tag, "_idle_after"}, bus.busy, 1'b0);
   endtask

   initial begin
      int dn;
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.value = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state and scan stepping every 4 cycles.
      check("rst_an_n",  an_n, 4'b1110);
      check("rst_digit", digit, 4'h0);
      check("rst_busy",  bus.busy, 1'b0);
      check("rst_done",  bus.done, 1'b0);
      check("rst_ovf",   bus.ovf, 1'b0);
      repeat (3) tick();
      check("scan_hold3", an_n, 4'b1110);
      tick(); check("scan_step1", an_n, 4'b1101);
      repeat (4) tick(); check("scan_step2", an_n, 4'b1011);
      repeat (4) tick(); check("scan_step3", an_n, 4'b0111);
      repeat (4) tick(); check("scan_wrap",  an_n, 4'b1110);

      convert("c1234", 14'd1234, 0, 14'd0);
      check("c1234_ovf", bus.ovf, 1'b0);
      check_digits("c1234", 4'd1, 4'd2, 4'd3, 4'd4);

      convert("c9999", 14'd9999, 0, 14'd0);
      check("c9999_ovf", bus.ovf, 1'b0);
      check_digits("c9999", 4'd9, 4'd9, 4'd9, 4'd9);

      convert("c0", 14'd0, 0, 14'd0);
      check("c0_ovf", bus.ovf, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("c0", 4'hF, 4'hF, 4'hF, 4'd0);
`else
      check_digits("c0", 4'd0, 4'd0, 4'd0, 4'd0);
`endif

      convert("c10000", 14'd10000, 0, 14'd0);
      check("c10000_ovf", bus.ovf, 1'b1);
      check_digits("c10000", 4'hF, 4'hF, 4'hF, 4'hF);

      convert("c5", 14'd5, 0, 14'd0);
      check("c5_ovf", bus.ovf, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("c5", 4'hF, 4'hF, 4'hF, 4'd5);
`else
      check_digits("c5", 4'd0, 4'd0, 4'd0, 4'd5);
`endif

      convert("c42", 14'd42, 0, 14'd0);
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("c42", 4'hF, 4'hF, 4'd4, 4'd2);
`else
      check_digits("c42", 4'd0, 4'd0, 4'd4, 4'd2);
`endif

      convert("c1002", 14'd1002, 0, 14'd0);
      check_digits("c1002", 4'd1, 4'd0, 4'd0, 4'd2);

      convert("c16383", 14'd16383, 0, 14'd0);
      check("c16383_ovf", bus.ovf, 1'b1);

      // Load during CONV (busy cycle 5) and during DONE (cycle 15) ignored.
      convert("hold5", 14'd1234, 5, 14'd5678);
      check_digits("hold5", 4'd1, 4'd2, 4'd3, 4'd4);
      convert("hold15", 14'd9876, 15, 14'd4321);
      check_digits("hold15", 4'd9, 4'd8, 4'd7, 4'd6);

      // Reset abort at cycle 7 of a conversion, with ovf previously set.
      convert("pre_abort", 14'd12000, 0, 14'd0);
      check("pre_abort_ovf", bus.ovf, 1'b1);
      bus.load  = 1'b1;
      bus.value = 14'd1234;
      tick();
      bus.load = 1'b0;
      repeat (6) tick();
      check("abort_busy_mid", bus.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_an_n",  an_n, 4'b1110);
      check("abort_digit", digit, 4'h0);
      check("abort_busy",  bus.busy, 1'b0);
      check("abort_done",  bus.done, 1'b0);
      check("abort_ovf",   bus.ovf, 1'b0);
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) dn++;
         tick();
      end
      check("abort_no_done", dn, 0);
      check_digits("abort", 4'd0, 4'd0, 4'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
